// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
// Holds the FSM encoding, sizing defaults and the range helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEPTH       = 32;
    localparam int DMEM_WAIT_CYCLES = 1;
    localparam int DMEM_IDX_W       = 5;

    // An address is in range when every bit above the word index is zero.
    function automatic logic dmem_in_range(
        input logic [31:0] addr_hi
    );
        return (addr_hi == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory responder.
// Synchronous write and clear, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = DMEM_IDX_W
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read returns contents before any same-edge write.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready load/store responder with configurable wait states.
// One request in flight; response held until the requester takes it.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_zero
);

    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_nxt;
    logic        w_enter_resp;
    logic        w_accept;
    logic        w_in_resp;

    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_op_write;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_op_wdata;
    logic              w_in_range;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [31:0]       w_addr_hi;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_in_resp = (r_state == ST_RESP);

    // With no wait states the op completes on the accept edge, so use
    // the live request in IDLE and the captured one otherwise.
    assign w_op_write = req_ready ? req_write : r_write;
    assign w_op_addr  = req_ready ? req_addr  : r_addr;
    assign w_op_wdata = req_ready ? req_wdata : r_wdata;

    assign w_addr_hi  = 32'(w_op_addr >> DMEM_IDX_W);
    assign w_in_range = dmem_in_range(w_addr_hi);
    assign w_mem_we   = w_enter_resp & w_op_write & w_in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (DMEM_IDX_W)
    ) u_array (
        .clk     (clk),
        .i_clr   (reset),
        .i_we    (w_mem_we),
        .i_waddr (w_op_addr[DMEM_IDX_W-1:0]),
        .i_wdata (w_op_wdata),
        .i_raddr (w_op_addr[DMEM_IDX_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Next-state logic; flags the edge that moves into RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WC == 3'd0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_wait_nxt  = WC - 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt - 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Register the response once, on entry to RESP, so it stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            if (w_op_write || !w_in_range) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_mem_rdata;
            end
            r_err <= !w_in_range;
        end
    end

    assign resp_valid = w_in_resp;
    assign resp_rdata = w_in_resp ? r_rdata : '0;
    assign resp_err   = w_in_resp & r_err;
    assign resp_zero  = w_in_resp & (r_rdata == '0);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Instance u_dut1 uses one wait state, u_dut0 uses none.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        v1, rdy1, rv1, err1, zero1;
    logic [31:0] rd1;
    logic        v0, rdy0, rv0, err0, zero0;
    logic [31:0] rd0;

    logic        sel;
    logic        m_rdy, m_rv, m_err, m_zero;
    logic [31:0] m_rd;

    int n_checks;
    int n_errors;

    data_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (v1),
        .req_ready  (rdy1),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rv1),
        .resp_ready (resp_ready),
        .resp_rdata (rd1),
        .resp_err   (err1),
        .resp_zero  (zero1)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (v0),
        .req_ready  (rdy0),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rv0),
        .resp_ready (resp_ready),
        .resp_rdata (rd0),
        .resp_err   (err0),
        .resp_zero  (zero0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to one set of names.
    always_comb begin
        m_rdy  = sel ? rdy0  : rdy1;
        m_rv   = sel ? rv0   : rv1;
        m_rd   = sel ? rd0   : rd1;
        m_err  = sel ? err0  : err1;
        m_zero = sel ? zero0 : zero1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction on instance s, with optional response stall.
    task automatic txn(input logic s, input logic wr,
                       input logic [9:0] a, input logic [31:0] d,
                       input int hold, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat);
        int lat;
        sel = s;
        @(negedge clk);
        chk("rdy_before", 32'(m_rdy), 32'd1);
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b0;
        if (s) v0 = 1'b1;
        else   v1 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        lat = 1;
        while (!m_rv && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rv", 32'(m_rv), 32'd1);
        chk("rdata", m_rd, exp_rd);
        chk("err", 32'(m_err), 32'(exp_err));
        chk("zero", 32'(m_zero), 32'(exp_rd == 32'd0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rv", 32'(m_rv), 32'd1);
            chk("hold_rdata", m_rd, exp_rd);
            chk("hold_rdy", 32'(m_rdy), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("done_rv", 32'(m_rv), 32'd0);
        chk("done_rdata", m_rd, 32'd0);
        chk("done_rdy", 32'(m_rdy), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sel        = 1'b0;
        reset      = 1'b1;
        v1         = 1'b0;
        v0         = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rdy", 32'(rdy1), 32'd1);
        chk("rst_rv", 32'(rv1), 32'd0);
        chk("rst_rdata", rd1, 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_zero", 32'(zero1), 32'd0);

        // Load of untouched word reads zero.
        txn(1'b0, 1'b0, 10'd7, 32'd0, 0, 32'd0, 1'b0, 2);
        // Store then load back.
        txn(1'b0, 1'b1, 10'd3, 32'hDEADBEEF, 0, 32'd0, 1'b0, 2);
        txn(1'b0, 1'b0, 10'd3, 32'd0, 0, 32'hDEADBEEF, 1'b0, 2);
        // Out-of-range store is dropped and flagged.
        txn(1'b0, 1'b1, 10'h020, 32'h5, 0, 32'd0, 1'b1, 2);
        txn(1'b0, 1'b0, 10'd0, 32'd0, 0, 32'd0, 1'b0, 2);
        txn(1'b0, 1'b0, 10'h3FF, 32'd0, 0, 32'd0, 1'b1, 2);
        // Stalled response stays stable.
        txn(1'b0, 1'b0, 10'd3, 32'd0, 4, 32'hDEADBEEF, 1'b0, 2);

        // Reset during WAIT abandons the store.
        sel = 1'b0;
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 10'd5;
        req_wdata = 32'h1;
        v1        = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("wait_rv", 32'(rv1), 32'd0);
        chk("wait_rdy", 32'(rdy1), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_rv", 32'(rv1), 32'd0);
        chk("abort_rdy", 32'(rdy1), 32'd1);
        txn(1'b0, 1'b0, 10'd5, 32'd0, 0, 32'd0, 1'b0, 2);
        // Earlier store wiped by that reset.
        txn(1'b0, 1'b0, 10'd3, 32'd0, 0, 32'd0, 1'b0, 2);

        // Zero-wait instance.
        txn(1'b1, 1'b1, 10'd31, 32'hFFFFFFFF, 0, 32'd0, 1'b0, 1);
        txn(1'b1, 1'b0, 10'd31, 32'd0, 1, 32'hFFFFFFFF, 1'b0, 1);
        txn(1'b1, 1'b0, 10'd30, 32'd0, 0, 32'd0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
